tick_gen_multi: RTL and testbench

Parametrised multi-channel tick and square-wave generator, replacing single-rate fixed clock dividers in the fan-control design. Each channel divides `i_clk` by a run-time programmable divisor. Each channel produces two outputs: a one-cycle tick pulse for clock-enable use, and a registered square wave. Consumers are the fan FSM, the PWM stage and the display refresh.

---
 rtl/tick_gen_pkg.sv | 26 ++
 rtl/tick_gen_channel.sv | 85 ++++++++
 rtl/tick_gen_multi.sv | 58 +++++
 tb/tb_tick_gen_multi.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_gen_pkg.sv
// Shared constants for the tick generator: system clock rate and common
// square-wave divisors (one tick per half-period).
package tick_gen_pkg;

  localparam int unsigned CLK_HZ = 100_000_000;

  localparam int unsigned DIV_1HZ   = CLK_HZ / (2 * 1);
  localparam int unsigned DIV_10HZ  = CLK_HZ / (2 * 10);
  localparam int unsigned DIV_1KHZ  = CLK_HZ / (2 * 1_000);
  localparam int unsigned DIV_25KHZ = CLK_HZ / (2 * 25_000);

  // Per-edge channel behaviour, highest priority first.
  typedef enum logic [1:0] {
    CH_SYNC,
    CH_IDLE,
    CH_STOP,
    CH_RUN
  } ch_mode_e;

  // Divisor giving a square wave of 'freq' Hz; 0 Hz maps to a stopped channel.
  function automatic int unsigned f_div(input int unsigned freq);
    if (freq == 0) return 0;
    return CLK_HZ / (2 * freq);
  endfunction

endpackage

// File: rtl/tick_gen_channel.sv
// One tick/square-wave channel: counter, shadowed divisor and output registers.
// A new divisor only lands on a period boundary, idle or stopped edge.
module tick_gen_channel
  import tick_gen_pkg::*;
#(
  parameter int unsigned DIV_W       = 32,
  parameter int unsigned DEFAULT_DIV = 50_000_000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_wr_en,
  input  logic [DIV_W-1:0] i_wr_div,
  output logic             o_tick,
  output logic             o_sq,
  output logic             o_pend
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;
  ch_mode_e         mode;
  logic             wrap;
  logic             apply;

  always_comb begin
    if (i_sync)              mode = CH_SYNC;
    else if (!i_en)          mode = CH_IDLE;
    else if (div_q == '0)    mode = CH_STOP;
    else                     mode = CH_RUN;
  end

  // cnt < div always holds, so the compare never sees an underflowed div-1.
  assign wrap  = (mode == CH_RUN) && (cnt_q == div_q - DIV_W'(1));
  assign apply = wrap || (mode != CH_RUN);

  always_comb begin
    cnt_d  = '0;
    tick_d = 1'b0;
    sq_d   = sq_q;
    case (mode)
      CH_RUN: begin
        if (wrap) begin
          tick_d = 1'b1;
          sq_d   = ~sq_q;
        end else begin
          cnt_d  = cnt_q + DIV_W'(1);
        end
      end
      CH_STOP: sq_d = sq_q;
      default: sq_d = 1'b0;
    endcase
    // Apply takes the old shadow; a write on the same edge stays pending.
    div_d    = apply ? shadow_q : div_q;
    shadow_d = i_wr_en ? i_wr_div : shadow_q;
    pend_d   = i_wr_en | (pend_q & ~apply);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      div_q    <= DIV_W'(DEFAULT_DIV);
      shadow_q <= DIV_W'(DEFAULT_DIV);
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      tick_q   <= 1'b0;
      sq_q     <= 1'b0;
    end else begin
      div_q    <= div_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      tick_q   <= tick_d;
      sq_q     <= sq_d;
    end
  end

  assign o_tick = tick_q;
  assign o_sq   = sq_q;
  assign o_pend = pend_q;

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel tick and square-wave generator with run-time divisors.
// Define TICK_GEN_SYNC_EN to add i_sync, which phase-aligns all channels.
module tick_gen_multi
  import tick_gen_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DIV_W       = 32,
  parameter int unsigned DEFAULT_DIV = 50_000_000,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
`ifdef TICK_GEN_SYNC_EN
  input  logic              i_sync,
`endif
  input  logic [NUM_CH-1:0] i_en,
  input  logic              i_wr_en,
  input  logic [CH_W-1:0]   i_wr_ch,
  input  logic [DIV_W-1:0]  i_wr_div,
  output logic [NUM_CH-1:0] o_tick,
  output logic [NUM_CH-1:0] o_sq,
  output logic [NUM_CH-1:0] o_pend
);

  logic              sync;
  logic [NUM_CH-1:0] wr_sel;

`ifdef TICK_GEN_SYNC_EN
  assign sync = i_sync;
`else
  assign sync = 1'b0;
`endif

  // Out-of-range channel numbers match no select and are dropped.
  always_comb begin
    wr_sel = '0;
    for (int c = 0; c < NUM_CH; c++)
      wr_sel[c] = i_wr_en && (i_wr_ch == CH_W'(c));
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    tick_gen_channel #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_en     (i_en[c]),
      .i_sync   (sync),
      .i_wr_en  (wr_sel[c]),
      .i_wr_div (i_wr_div),
      .o_tick   (o_tick[c]),
      .o_sq     (o_sq[c]),
      .o_pend   (o_pend[c])
    );
  end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Bench for tick_gen_multi: directed scenarios plus random traffic, checked
// against a period/phase reference model on a 4-channel and a 6-channel build.
module tb_tick_gen_multi;

  localparam int DW = 16;
  localparam int NCH[2] = '{4, 6};

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic [5:0]    en;
  logic          wr_en;
  logic [2:0]    wr_ch;
  logic [DW-1:0] wr_div;
  logic          sync;
  logic [3:0]    tick_a, sq_a, pend_a;
  logic [5:0]    tick_b, sq_b, pend_b;

  int n_chk = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  tick_gen_multi #(.NUM_CH(4), .DIV_W(DW), .DEFAULT_DIV(5)) dut_a (
    .i_clk(i_clk), .i_reset(i_reset),
`ifdef TICK_GEN_SYNC_EN
    .i_sync(sync),
`endif
    .i_en(en[3:0]), .i_wr_en(wr_en), .i_wr_ch(wr_ch[1:0]), .i_wr_div(wr_div),
    .o_tick(tick_a), .o_sq(sq_a), .o_pend(pend_a)
  );

  tick_gen_multi #(.NUM_CH(6), .DIV_W(DW), .DEFAULT_DIV(5)) dut_b (
    .i_clk(i_clk), .i_reset(i_reset),
`ifdef TICK_GEN_SYNC_EN
    .i_sync(sync),
`endif
    .i_en(en), .i_wr_en(wr_en), .i_wr_ch(wr_ch), .i_wr_div(wr_div),
    .o_tick(tick_b), .o_sq(sq_b), .o_pend(pend_b)
  );

  // Reference model: edges elapsed in the current period, plus divisor bookkeeping.
  int unsigned m_div[2][8], m_sh[2][8], m_ph[2][8];
  bit          m_pend[2][8], m_tick[2][8], m_sq[2][8];

  task automatic m_reset();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 8; c++) begin
        m_div[d][c] = 5; m_sh[d][c] = 5; m_ph[d][c] = 0;
        m_pend[d][c] = 0; m_tick[d][c] = 0; m_sq[d][c] = 0;
      end
  endtask

  task automatic m_step();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NCH[d]; c++) begin
        bit wr, run, done;
        int tgt;
        tgt  = (d == 0) ? int'(wr_ch[1:0]) : int'(wr_ch);
        wr   = wr_en && (tgt == c);
        run  = en[c] && (m_div[d][c] != 0) && !sync;
        done = run && (m_ph[d][c] + 1 == m_div[d][c]);
        if (!run) begin
          m_ph[d][c] = 0; m_tick[d][c] = 0;
          if (sync || !en[c]) m_sq[d][c] = 0;
        end else if (done) begin
          m_ph[d][c] = 0; m_tick[d][c] = 1; m_sq[d][c] = !m_sq[d][c];
        end else begin
          m_ph[d][c]++; m_tick[d][c] = 0;
        end
        if (!run || done) begin
          m_div[d][c] = m_sh[d][c];
          m_pend[d][c] = 0;
        end
        if (wr) begin
          m_sh[d][c] = int'(wr_div); m_pend[d][c] = 1;
        end
      end
  endtask

  function automatic logic [7:0] m_vec(int d, int sel);
    logic [7:0] v = '0;
    for (int c = 0; c < NCH[d]; c++)
      v[c] = (sel == 0) ? m_tick[d][c] : (sel == 1) ? m_sq[d][c] : m_pend[d][c];
    return v;
  endfunction

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, "_tickA"}, {4'b0, tick_a}, m_vec(0, 0));
    chk({tag, "_sqA"},   {4'b0, sq_a},   m_vec(0, 1));
    chk({tag, "_pendA"}, {4'b0, pend_a}, m_vec(0, 2));
    chk({tag, "_tickB"}, {2'b0, tick_b}, m_vec(1, 0));
    chk({tag, "_sqB"},   {2'b0, sq_b},   m_vec(1, 1));
    chk({tag, "_pendB"}, {2'b0, pend_b}, m_vec(1, 2));
  endtask

  task automatic step();
    @(posedge i_clk);
    m_step();
    @(negedge i_clk);
    check_all("cyc");
  endtask

  task automatic write(int ch, int dv);
    wr_en = 1'b1; wr_ch = 3'(ch); wr_div = DW'(dv);
    step();
    wr_en = 1'b0;
  endtask

  // Called at a negedge: asynchronous reset pulse that never spans a clock edge.
  task automatic do_reset();
    #2 i_reset = 1'b1;
    #1 m_reset();
    check_all("areset");
    #1 i_reset = 1'b0;
  endtask

  initial begin
    logic hold;
    i_reset = 1'b0; en = '0; wr_en = 1'b0; wr_ch = '0; wr_div = '0; sync = 1'b0;
    #1 i_reset = 1'b1;
    #2 m_reset();
    check_all("reset");
    @(negedge i_clk);
    i_reset = 1'b0;

    // Default divisor 5 on all channels, ticks after every 5th edge.
    en = '1;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk("d5_tick0", {7'b0, tick_a[0]}, 8'((k % 5) == 0));
      chk("d5_sq0",   {7'b0, sq_a[0]},   8'((k / 5) % 2));
    end

    // Divisor 3 written mid-period at cnt=2: old period completes first.
    do_reset();
    step(); step();
    write(1, 3);
    chk("mid_pend1", {7'b0, pend_a[1]}, 8'd1);
    step();
    chk("mid_tick1_early", {7'b0, tick_a[1]}, 8'd0);
    step();
    chk("mid_tick1_wrap", {7'b0, tick_a[1]}, 8'd1);
    chk("mid_pend1_clr",  {7'b0, pend_a[1]}, 8'd0);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("d3_tick1", {7'b0, tick_a[1]}, 8'((k % 3) == 0));
    end

    // Write landing on the wrap edge: old shadow applies, new one stays pending.
    write(1, 2);
    step();
    write(1, 4);
    chk("wrapwr_tick", {7'b0, tick_a[1]}, 8'd1);
    chk("wrapwr_pend", {7'b0, pend_a[1]}, 8'd1);
    step();
    step();
    chk("wrapwr_d2_tick", {7'b0, tick_a[1]}, 8'd1);
    chk("wrapwr_d2_pend", {7'b0, pend_a[1]}, 8'd0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("d4_tick1", {7'b0, tick_a[1]}, 8'(k == 4));
    end

    // Divisor 0 stops channel 2 after its period; divisor 1 then ticks every cycle.
    write(2, 0);
    for (int k = 0; k < 6; k++) step();
    hold = sq_a[2];
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stop_tick2", {7'b0, tick_a[2]}, 8'd0);
      chk("stop_sq2",   {7'b0, sq_a[2]},   {7'b0, hold});
    end
    write(2, 1);
    chk("d1_pend2", {7'b0, pend_a[2]}, 8'd1);
    step();
    chk("d1_pend2_clr", {7'b0, pend_a[2]}, 8'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("d1_tick2", {7'b0, tick_a[2]}, 8'd1);
    end

    // Out-of-range channel on the 6-channel build is ignored.
    write(7, 2);
    chk("oor_pendB", {2'b0, pend_b}, 8'd0);
    step();

    // Drop enable on channel 0 mid-period, then a full period on re-enable.
    step(); step();
    en[0] = 1'b0;
    step();
    chk("dis_sq0",   {7'b0, sq_a[0]},   8'd0);
    chk("dis_tick0", {7'b0, tick_a[0]}, 8'd0);
    en[0] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("reen_tick0", {7'b0, tick_a[0]}, 8'(k == 5));
    end

`ifdef TICK_GEN_SYNC_EN
    // Divisors 4 and 6, one sync pulse, then both phases measured from it.
    do_reset();
    en = '0;
    write(0, 4);
    write(1, 6);
    step();
    en = '1;
    for (int k = 0; k < 7; k++) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_sqA", {4'b0, sq_a}, 8'd0);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("sync_tick0", {7'b0, tick_a[0]}, 8'((k % 4) == 0));
      chk("sync_tick1", {7'b0, tick_a[1]}, 8'((k % 6) == 0));
    end
    do_reset();
`endif

    // Random traffic against the model, with occasional async resets.
    for (int k = 0; k < 600; k++) begin
      for (int c = 0; c < 6; c++) en[c] = ($urandom_range(7) != 0);
      wr_en  = ($urandom_range(3) == 0);
      wr_ch  = 3'($urandom_range(7));
      wr_div = DW'($urandom_range(6));
`ifdef TICK_GEN_SYNC_EN
      sync   = ($urandom_range(39) == 0);
`endif
      step();
      if ($urandom_range(79) == 0) do_reset();
    end
    wr_en = 1'b0; sync = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
